// File: rtl/sar_pkg.sv
// sar_pkg: shared SAR controller state encodings, default result width and averager FSM state type.
package sar_pkg;
  localparam logic [1:0] SAR_IDLE  = 2'b00;
  localparam logic [1:0] SAR_TRACK = 2'b01;
  localparam logic [1:0] SAR_STEP  = 2'b10;
  localparam logic [1:0] SAR_INIT  = 2'b11;
  localparam int SAR_DATA = 8;
  typedef enum logic {ACCUM, LOAD} avg_state_t;
endpackage

// File: rtl/sar_done_detect.sv
// sar_done_detect: one-cycle conversion-done pulse when the SAR controller returns to idle.
module sar_done_detect
  import sar_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] StateP,
  output logic       done
);
  logic [1:0] prev;
  always_ff @(posedge Clock) prev <= !Reset ? SAR_IDLE : StateP;
  assign done = prev != SAR_IDLE && StateP == SAR_IDLE;
endmodule

// File: rtl/sar_result_avg.sv
// sar_result_avg: block-averages 2^AVG_LOG2 SAR results with a valid/ready output and sticky overrun.
// Define SAR_AVG_ROUND_EN to round the average to nearest instead of truncating.
module sar_result_avg
  import sar_pkg::*;
#(
  parameter int DATA     = SAR_DATA,
  parameter int AVG_LOG2 = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Enable,
  input  logic [1:0]          StateP,
  input  logic [DATA-1:0]     SAROut,
  output logic [DATA-1:0]     AvgOut,
  output logic                AvgValid,
  input  logic                AvgReady,
  output logic                Overrun,
  output logic [AVG_LOG2:0]   SampleCnt
);
  localparam int ACC_W = DATA + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FULL = (AVG_LOG2 + 1)'(2 ** AVG_LOG2);
  logic done, capture, restart;
  avg_state_t state;
  logic [ACC_W-1:0] acc, rounded, sample;
  logic [DATA-1:0] result;
  sar_done_detect u_done (.Clock(Clock), .Reset(Reset), .StateP(StateP), .done(done));
  assign capture = done && Enable;
  assign sample  = ACC_W'(SAROut);
  assign restart = state == LOAD || !Enable;
`ifdef SAR_AVG_ROUND_EN
  assign rounded = acc + ACC_W'((2 ** AVG_LOG2) / 2);
`else
  assign rounded = acc;
`endif
  assign result = DATA'(rounded >> AVG_LOG2);
  // A new result meeting an unaccepted one is dropped; a same-cycle transfer frees the slot.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= ACCUM;
      acc       <= '0;
      SampleCnt <= '0;
      AvgOut    <= '0;
      AvgValid  <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      state     <= (state == ACCUM && capture && SampleCnt + 1'b1 == FULL) ? LOAD : ACCUM;
      acc       <= restart ? (capture ? sample : '0) : (capture ? acc + sample : acc);
      SampleCnt <= restart ? (AVG_LOG2 + 1)'(capture) : SampleCnt + (AVG_LOG2 + 1)'(capture);
      if (state == LOAD) begin
        if (AvgValid && !AvgReady) Overrun <= 1'b1;
        else begin
          AvgOut   <= result;
          AvgValid <= 1'b1;
        end
      end else if (AvgReady) AvgValid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sar_result_avg.sv
// tb_sar_result_avg: scoreboard bench for sar_result_avg (DATA=8, AVG_LOG2=2).
module tb_sar_result_avg;
  import sar_pkg::*;
  logic       Clock = 1'b0, Reset = 1'b0, Enable = 1'b0, AvgReady = 1'b0;
  logic [1:0] StateP = SAR_IDLE;
  logic [7:0] SAROut = '0;
  logic [7:0] AvgOut;
  logic       AvgValid, Overrun;
  logic [2:0] SampleCnt;
  int checks = 0, fails = 0;
  logic [7:0] exp_q[$], obs_q[$];
`ifdef SAR_AVG_ROUND_EN
  localparam logic [7:0] RND_EXP = 8'd2;
`else
  localparam logic [7:0] RND_EXP = 8'd1;
`endif

  always #5 Clock = ~Clock;

  sar_result_avg #(.DATA(8), .AVG_LOG2(2)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .StateP(StateP), .SAROut(SAROut),
    .AvgOut(AvgOut), .AvgValid(AvgValid), .AvgReady(AvgReady), .Overrun(Overrun),
    .SampleCnt(SampleCnt)
  );

  // Inputs change 2ns after posedge, so the negedge sees what the next edge will act on.
  always @(negedge Clock) if (Reset && AvgValid && AvgReady) obs_q.push_back(AvgOut);

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge Clock);
      #2;
    end
  endtask

  task automatic capture(input logic [7:0] v);
    StateP = SAR_STEP;
    step();
    StateP = SAR_IDLE;
    SAROut = v;
    step();
  endtask

  task automatic apply_reset();
    Reset = 1'b0; Enable = 1'b0; AvgReady = 1'b0; StateP = SAR_IDLE; SAROut = '0;
    step(2);
    Reset = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({AvgOut, AvgValid, Overrun, SampleCnt} !== 13'd0) begin
      fails++;
      $display("FAIL reset_state: out=%0d valid=%b ovr=%b cnt=%0d, expected all 0", AvgOut, AvgValid, Overrun, SampleCnt);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    Enable = 1'b1; AvgReady = 1'b1;
    capture(10); capture(20);
    checks++;
    if (SampleCnt !== 3'd2) begin fails++; $display("FAIL basic_cnt: got %0d expected 2", SampleCnt); end
    capture(30); capture(40);
    exp_q.push_back(8'd25);
    checks++;
    if (AvgValid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b expected 0", AvgValid); end
    step();
    checks++;
    if (AvgValid !== 1'b1 || AvgOut !== 8'd25) begin
      fails++; $display("FAIL basic_result: valid=%b out=%0d expected valid=1 out=25", AvgValid, AvgOut);
    end
    step();
    checks++;
    if (AvgValid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop: got %b expected 0", AvgValid); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL basic_xfers: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin fails++; $display("FAIL basic_sb: got %0d expected %0d", o, e); end
    end
  endtask

  task automatic test_round();
    apply_reset();
    Enable = 1'b1; AvgReady = 1'b1;
    capture(1); capture(2); capture(2); capture(2);
    exp_q.push_back(RND_EXP);
    step();
    checks++;
    if (AvgValid !== 1'b1 || AvgOut !== RND_EXP) begin
      fails++; $display("FAIL round_result: valid=%b out=%0d expected valid=1 out=%0d", AvgValid, AvgOut, RND_EXP);
    end
    step();
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin fails++; $display("FAIL round_sb: got %0d expected %0d", o, e); end
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    Enable = 1'b1;
    capture(10); capture(20); capture(30); capture(40);
    exp_q.push_back(8'd25);
    capture(40); capture(50); capture(60); capture(50);
    step(2);
    checks++;
    if (AvgOut !== 8'd25 || AvgValid !== 1'b1 || Overrun !== 1'b1) begin
      fails++; $display("FAIL overrun_hold: out=%0d valid=%b ovr=%b expected out=25 valid=1 ovr=1", AvgOut, AvgValid, Overrun);
    end
    AvgReady = 1'b1;
    step(3);
    checks++;
    if (AvgValid !== 1'b0 || Overrun !== 1'b1) begin
      fails++; $display("FAIL overrun_after: valid=%b ovr=%b expected valid=0 ovr=1", AvgValid, Overrun);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL overrun_xfers: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin fails++; $display("FAIL overrun_sb: got %0d expected %0d", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    Enable = 1'b1;
    capture(10); capture(20); capture(30); capture(40);
    exp_q.push_back(8'd25);
    capture(4); capture(8); capture(12); capture(16);
    exp_q.push_back(8'd10);
    AvgReady = 1'b1;
    step();
    checks++;
    if (AvgValid !== 1'b1 || AvgOut !== 8'd10 || Overrun !== 1'b0) begin
      fails++; $display("FAIL b2b_load: valid=%b out=%0d ovr=%b expected valid=1 out=10 ovr=0", AvgValid, AvgOut, Overrun);
    end
    step();
    checks++;
    if (AvgValid !== 1'b0) begin fails++; $display("FAIL b2b_drain: valid=%b expected 0", AvgValid); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL b2b_xfers: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin fails++; $display("FAIL b2b_sb: got %0d expected %0d", o, e); end
    end
  endtask

  task automatic test_enable_clear();
    apply_reset();
    Enable = 1'b1; AvgReady = 1'b1;
    capture(7); capture(9);
    Enable = 1'b0;
    step();
    checks++;
    if (SampleCnt !== 3'd0) begin fails++; $display("FAIL enable_clear_cnt: got %0d expected 0", SampleCnt); end
    Enable = 1'b1;
    capture(100); capture(100); capture(100); capture(100);
    exp_q.push_back(8'd100);
    step();
    checks++;
    if (AvgOut !== 8'd100 || AvgValid !== 1'b1 || SampleCnt !== 3'd0) begin
      fails++; $display("FAIL enable_result: out=%0d valid=%b cnt=%0d expected out=100 valid=1 cnt=0", AvgOut, AvgValid, SampleCnt);
    end
    step();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL enable_xfers: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin fails++; $display("FAIL enable_sb: got %0d expected %0d", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    Enable = 1'b1; AvgReady = 1'b1;
    capture(1); capture(2); capture(3);
    checks++;
    if (SampleCnt !== 3'd3) begin fails++; $display("FAIL midreset_cnt: got %0d expected 3", SampleCnt); end
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    checks++;
    if ({AvgOut, AvgValid, Overrun, SampleCnt} !== 13'd0) begin
      fails++; $display("FAIL midreset_outputs: out=%0d valid=%b ovr=%b cnt=%0d expected all 0", AvgOut, AvgValid, Overrun, SampleCnt);
    end
    step(4);
    checks++;
    if (SampleCnt !== 3'd0 || AvgValid !== 1'b0) begin
      fails++; $display("FAIL midreset_idle: cnt=%0d valid=%b expected cnt=0 valid=0", SampleCnt, AvgValid);
    end
    capture(8); capture(8); capture(8); capture(8);
    exp_q.push_back(8'd8);
    step();
    checks++;
    if (AvgOut !== 8'd8 || AvgValid !== 1'b1) begin
      fails++; $display("FAIL midreset_fresh: out=%0d valid=%b expected out=8 valid=1", AvgOut, AvgValid);
    end
    step();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL midreset_xfers: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin fails++; $display("FAIL midreset_sb: got %0d expected %0d", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_overrun();
    test_back_to_back();
    test_enable_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
